spi_xip_reader: RTL

- Memory-mapped flash read engine placed directly upstream of the APB SPI master controller.
- Converts single 32-bit read requests from the SoC fabric into a fixed APB programming sequence: load TX, set divider and slave select, start, poll GO, fetch RX.
- Issues a standard 0x03 READ command (8-bit cmd, 24-bit address, 32 data bits) as one 64-bit SPI character.
- Returns the read word, optionally byte-swapped, with an error flag.

---
 rtl/spi_xip_reader_if.sv | 32 +++
 rtl/spi_xip_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spi_xip_reader_if.sv
// Request/response and APB signals of the XIP flash reader.
// 'master' is the reader core's view: it accepts fabric requests and
// masters the APB bus of the SPI controller. 'slave' is the opposite
// view, used by the fabric side and the SPI controller.
interface spi_xip_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [4:0]  m_paddr;
    logic        m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [31:0] m_pwdata;
    logic [31:0] m_prdata;
    logic        m_pready;
    logic        m_pslverr;

    modport master (
        input  req_valid, req_addr, m_prdata, m_pready, m_pslverr,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               m_paddr, m_psel, m_penable, m_pwrite, m_pwdata
    );

    modport slave (
        output req_valid, req_addr, m_prdata, m_pready, m_pslverr,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               m_paddr, m_psel, m_penable, m_pwrite, m_pwdata
    );
endinterface

// File: rtl/spi_xip_reader.sv
// XIP flash read engine: turns one 24-bit address request into a fixed
// APB programming sequence on the SPI master controller (TX1, TX0,
// DIVIDER, SS, CTRL, poll GO, read RX0) and returns the 32-bit word.
module spi_xip_reader #(
    parameter logic [15:0] DIVIDER    = 16'd1,
    parameter logic [7:0]  SS_MASK    = 8'h01,
    parameter logic [7:0]  CMD        = 8'h03,
    parameter logic [15:0] POLL_MAX   = 16'd1024,
    parameter bit          SWAP_BYTES = 1'b1
) (
    input logic              PCLK,
    input logic              PRESETN,
    spi_xip_reader_if.master bus
);
    localparam logic [4:0]  REG_RX0    = 5'h00;
    localparam logic [4:0]  REG_TX0    = 5'h00;
    localparam logic [4:0]  REG_TX1    = 5'h04;
    localparam logic [4:0]  REG_CTRL   = 5'h10;
    localparam logic [4:0]  REG_DIV    = 5'h14;
    localparam logic [4:0]  REG_SS     = 5'h18;
    // 64-bit character, GO, TX on negedge, automatic slave select
    localparam logic [31:0] CTRL_VALUE = 32'h0000_2540;

    typedef enum logic [3:0] {
        IDLE, WR_TX1, WR_TX0, WR_DIV, WR_SS, WR_CTRL, POLL, RD_RX, RESP
    } state_t;

    typedef struct packed {
        logic [4:0]  paddr;
        logic        pwrite;
        logic [31:0] pwdata;
    } apb_cmd_t;

    state_t      state;
    state_t      launch_state;
    logic        launch;
    apb_cmd_t    launch_cmd;
    logic [23:0] addr_q;
    logic [15:0] poll_cnt;
    logic        err_q;
    logic        rx_ok;
    logic [31:0] rx_data;
    logic [31:0] rd_swapped;
    logic        access_done;
    logic        poll_last;

    function automatic apb_cmd_t cmd_for(input state_t s, input logic [23:0] a);
        apb_cmd_t c;
        c = '{5'h00, 1'b0, 32'h0};
        case (s)
            WR_TX1:  c = '{REG_TX1, 1'b1, {CMD, a}};
            WR_TX0:  c = '{REG_TX0, 1'b1, 32'h0};
            WR_DIV:  c = '{REG_DIV, 1'b1, {16'h0, DIVIDER}};
            WR_SS:   c = '{REG_SS, 1'b1, {24'h0, SS_MASK}};
            WR_CTRL: c = '{REG_CTRL, 1'b1, CTRL_VALUE};
            POLL:    c = '{REG_CTRL, 1'b0, 32'h0};
            RD_RX:   c = '{REG_RX0, 1'b0, 32'h0};
            default: c = '{5'h00, 1'b0, 32'h0};
        endcase
        return c;
    endfunction

    function automatic state_t next_write(input state_t s);
        state_t n;
        case (s)
            WR_TX1:  n = WR_TX0;
            WR_TX0:  n = WR_DIV;
            WR_DIV:  n = WR_SS;
            WR_SS:   n = WR_CTRL;
            WR_CTRL: n = POLL;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    assign access_done = bus.m_psel && bus.m_penable && bus.m_pready;
    assign poll_last   = (poll_cnt + 16'd1) == POLL_MAX;
    assign rd_swapped  = SWAP_BYTES ? {bus.m_prdata[7:0], bus.m_prdata[15:8],
                                       bus.m_prdata[23:16], bus.m_prdata[31:24]}
                                    : bus.m_prdata;
    // The first access takes its address straight from the request port.
    assign launch_cmd  = cmd_for(launch_state, (state == IDLE) ? bus.req_addr : addr_q);

    // Decide whether a new APB SETUP starts next cycle, and for which state.
    always_comb begin
        launch       = 1'b0;
        launch_state = IDLE;
        if (state == IDLE) begin
            if (bus.req_valid) begin
                launch       = 1'b1;
                launch_state = WR_TX1;
            end
        end else if (access_done && !bus.m_pslverr) begin
            case (state)
                POLL: begin
                    if (!bus.m_prdata[8]) begin
                        launch       = 1'b1;
                        launch_state = RD_RX;
                    end else if (!poll_last) begin
                        launch       = 1'b1;
                        launch_state = POLL;
                    end
                end
                RD_RX, RESP: launch = 1'b0;
                default: begin
                    launch       = 1'b1;
                    launch_state = next_write(state);
                end
            endcase
        end
    end

    // Sequencer FSM with registered APB master and response outputs.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state         <= IDLE;
            addr_q        <= '0;
            poll_cnt      <= '0;
            err_q         <= 1'b0;
            rx_ok         <= 1'b0;
            rx_data       <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.m_paddr   <= '0;
            bus.m_psel    <= 1'b0;
            bus.m_penable <= 1'b0;
            bus.m_pwrite  <= 1'b0;
            bus.m_pwdata  <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        addr_q        <= bus.req_addr;
                        poll_cnt      <= '0;
                        err_q         <= 1'b0;
                        rx_ok         <= 1'b0;
                        bus.req_ready <= 1'b0;
                        state         <= WR_TX1;
                    end
                end
                RESP: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= err_q;
                    bus.rsp_data  <= rx_ok ? rx_data : 32'h0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    if (!bus.m_penable) begin
                        bus.m_penable <= 1'b1;
                    end else if (bus.m_pready) begin
                        if (bus.m_pslverr) begin
                            err_q <= 1'b1;
                        end else if (state == RD_RX) begin
                            rx_data <= rd_swapped;
                            rx_ok   <= 1'b1;
                        end else if (state == POLL && bus.m_prdata[8]) begin
                            poll_cnt <= poll_cnt + 16'd1;
                            if (poll_last) begin
                                err_q <= 1'b1;
                            end
                        end
                        state <= launch ? launch_state : RESP;
                    end
                end
            endcase

            if (launch) begin
                bus.m_psel    <= 1'b1;
                bus.m_penable <= 1'b0;
                bus.m_paddr   <= launch_cmd.paddr;
                bus.m_pwrite  <= launch_cmd.pwrite;
                bus.m_pwdata  <= launch_cmd.pwdata;
            end else if (access_done) begin
                bus.m_psel    <= 1'b0;
                bus.m_penable <= 1'b0;
            end
        end
    end
endmodule
